// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and constants for the bit-serial adder
//
// Contents:
//   DEFAULT_WIDTH  default operand width in bits
//   state_t        control FSM states (IDLE, RUN, DONE)
package serial_adder_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fulladder.sv
// rtl/fulladder.sv - 1-bit full-adder cell
//
// Ports:
//   a, b, cin  input   addend bits and carry-in
//   s          output  sum bit
//   cout       output  carry-out
module fulladder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, one bit per clock, LSB first
//
// Ports:
//   clk        input         rising-edge clock
//   reset      input         asynchronous active-high reset
//   in_valid   input         operands present
//   in_ready   output        high only while idle; accept = in_valid & in_ready
//   a, b       input  WIDTH  operands (unsigned or two's complement)
//   cin        input         carry-in
//   out_valid  output        high only while a finished result is held
//   out_ready  input         consumer takes the result
//   sum        output WIDTH  a + b + cin modulo 2^WIDTH
//   cout       output        carry out of the MSB
//   ovf        output        signed overflow (carry into MSB xor carry out)
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
  localparam logic [CW-1:0] PENULT_BIT = CW'(WIDTH - 2);

  state_t state;
  state_t next_state;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             c_msb;
  logic             cout_q;
  logic             ovf_q;
  logic             fa_s;
  logic             fa_c;
  logic             last_bit;

  assign last_bit = (cnt == LAST_BIT);

  fulladder u_fa (
    .a    (a_sh[0]),
    .b    (b_sh[0]),
    .cin  (carry),
    .s    (fa_s),
    .cout (fa_c)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (in_valid)  next_state = RUN;
      RUN:     if (last_bit)  next_state = DONE;
      DONE:    if (out_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  // Datapath. The result register fills from the MSB end, so after WIDTH
  // shifts bit 0 of the operands has landed in res[0].
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res    <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      c_msb  <= 1'b0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            cnt   <= '0;
          end
        end
        RUN: begin
          res   <= {fa_s, res[WIDTH-1:1]};
          a_sh  <= {1'b0, a_sh[WIDTH-1:1]};
          b_sh  <= {1'b0, b_sh[WIDTH-1:1]};
          carry <= fa_c;
          cnt   <= cnt + CW'(1);
          // The cell carry out of bit WIDTH-2 is the carry into the MSB.
          if (cnt == PENULT_BIT) begin
            c_msb <= fa_c;
          end
          if (last_bit) begin
            cout_q <= fa_c;
            ovf_q  <= c_msb ^ fa_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = res;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder
module tb_serial_adder;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         v;
  } exp_t;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int   checks;
  int   errors;
  exp_t sb[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
    end
  endtask

  // Reference model: plain integer arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc);
    exp_t e;
    int unsigned full;
    full = int'(ta) + int'(tb) + int'(tc);
    e.s = full[W-1:0];
    e.c = full[W];
    e.v = (ta[W-1] == tb[W-1]) && (e.s[W-1] != ta[W-1]);
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops one expectation per output handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got sum %0h with no pending operation", sum);
        end else begin
          e = sb.pop_front();
          chk("sum", 32'(sum), 32'(e.s));
          chk("cout", 32'(cout), 32'(e.c));
          chk("ovf", 32'(ovf), 32'(e.v));
        end
      end
    end
  end

  // One full operation: wait for idle, accept, measure latency, hold the
  // result for 'hold' cycles, then release with a competing in_valid that
  // must not be taken on the releasing edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                      input int hold, input bit junk);
    int n;
    logic [W-1:0] s0;
    logic c0;
    logic v0;
    n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", 32'(in_ready), 32'd1);
    a = ta;
    b = tb;
    cin = tc;
    in_valid = 1'b1;
    sb.push_back(model(ta, tb, tc));
    step();
    in_valid = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    cin = 1'($urandom);
    n = 1;
    while (!out_valid && n < 50) begin
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (junk && n == 3) begin
        in_valid = 1'b1;
        a = 8'hAA;
        b = 8'h55;
        cin = 1'b0;
      end else begin
        in_valid = 1'b0;
      end
      out_ready = 1'($urandom);
      step();
      n++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("latency", 32'(n), 32'(W + 1));
    s0 = sum;
    c0 = cout;
    v0 = ovf;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_stable", {22'd0, v0 ^ ovf, c0 ^ cout, s0 ^ sum}, 32'd0);
    end
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = W'($urandom);
    b = W'($urandom);
    step();
    chk("release_out_valid", 32'(out_valid), 32'd0);
    chk("release_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    out_ready = 1'b0;
  endtask

  initial begin
    int n;
    checks = 0;
    errors = 0;
    reset = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    cin = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", {23'd0, ovf, cout, sum}, 32'd0);
    step();
    reset = 1'b0;

    send(8'h0F, 8'h01, 1'b0, 0, 1'b0);
    send(8'hFF, 8'h01, 1'b0, 1, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 0, 1'b0);
    send(8'hFF, 8'hFF, 1'b1, 2, 1'b0);
    send(8'h00, 8'h00, 1'b1, 0, 1'b0);
    send(8'h80, 8'h80, 1'b0, 0, 1'b0);
    send(8'h12, 8'h34, 1'b0, 0, 1'b1);
    send(8'h5A, 8'hC3, 1'b1, 20, 1'b0);

    // Abort an operation three edges into RUN.
    a = 8'h77;
    b = 8'h11;
    cin = 1'b0;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("abort_busy", 32'(in_ready), 32'd0);
    reset = 1'b1;
    #1;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_outputs", {23'd0, ovf, cout, sum}, 32'd0);
    step();
    reset = 1'b0;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    send(8'h01, 8'h01, 1'b0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      send(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
    end

    n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
